mem_stage: RTL and testbench

Memory-access stage of the five-stage RISC-V pipeline, directly downstream of the execute stage via the EX/MEM register. It takes the ALU op, write-back tag, store data/ALU result and effective address, and performs loads and stores over a byte-wide request/ready memory port. Non-memory ops pass through in one cycle. It stalls upstream while a transfer is in progress and delivers a registered result to the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 66 ++++++
 rtl/mem_load_ext.sv | 22 ++
 rtl/mem_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_stage.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types, op codes and helpers for the memory-access pipeline stage.
// Op codes mirror the AluOpBus encoding used by the decoder.
package mem_stage_pkg;

  localparam int unsigned ALUOP_W   = 8;
  localparam int unsigned REG_W     = 32;
  localparam int unsigned REGADDR_W = 5;
  localparam int unsigned BYTE_W    = 8;

  localparam logic [ALUOP_W-1:0] OP_NOP = 8'h00;
  localparam logic [ALUOP_W-1:0] OP_ADD = 8'h20;
  localparam logic [ALUOP_W-1:0] OP_LB  = 8'he0;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'he1;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'he3;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'he4;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'he5;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'he8;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'he9;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'heb;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Write-back payload handed to the MEM/WB register.
  typedef struct packed {
    logic                 valid;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
    logic [REG_W-1:0]     data;
  } wb_t;

  function automatic logic is_load(input logic [ALUOP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [ALUOP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(input logic [ALUOP_W-1:0] op);
    return is_load(op) || is_store(op);
  endfunction

  // Index of the final byte of a transfer (N-1).
  function automatic logic [1:0] last_byte(input logic [ALUOP_W-1:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      OP_LW, OP_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [ALUOP_W-1:0] op,
                                         input logic [REG_W-1:0]   addr);
    case (op)
      OP_LH, OP_LHU, OP_SH: return addr[0];
      OP_LW, OP_SW:         return addr[1:0] != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load extender: turns the assembled little-endian word into the write-back
// value according to the load op.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [REG_W-1:0]   word,
  output logic [REG_W-1:0]   value_c
);

  always_comb begin
    value_c = word;
    case (aluop)
      OP_LB:   value_c = {{24{word[7]}}, word[7:0]};
      OP_LBU:  value_c = {24'h000000, word[7:0]};
      OP_LH:   value_c = {{16{word[15]}}, word[15:0]};
      OP_LHU:  value_c = {16'h0000, word[15:0]};
      default: value_c = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: pass-through for ALU ops, byte-serial loads/stores over
// a request/ready port. Optional alignment trap: MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [ALUOP_W-1:0]   aluop_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic [REG_W-1:0]     data_i,
  input  logic [REG_W-1:0]     mem_addr_i,
  output logic                 stall_req_o,
  output logic                 valid_o,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [REG_W-1:0]     data_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [REG_W-1:0]     mem_addr_o,
  output logic [BYTE_W-1:0]    mem_wdata_o,
  input  logic [BYTE_W-1:0]    mem_rdata_i,
  input  logic                 mem_ready_i
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 misalign_o
`endif
);

  state_t               state_q, state_n;
  logic [ALUOP_W-1:0]   op_q, op_n;
  logic [REG_W-1:0]     addr_q, addr_n;
  logic [REG_W-1:0]     sdata_q, sdata_n;
  logic [REGADDR_W-1:0] wd_q, wd_n;
  logic                 wreg_q, wreg_n;
  logic [1:0]           k_q, k_n;
  logic [1:0]           last_q, last_n;
  logic [REG_W-1:0]     word_q, word_n;
  wb_t                  wb_q, wb_n;
  logic [REG_W-1:0]     word_asm;
  logic [REG_W-1:0]     load_val;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                 misalign_q, misalign_n;
`endif

  // Word with the byte arriving this cycle merged in at position k.
  always_comb begin
    word_asm = word_q;
    word_asm[{k_q, 3'b000} +: BYTE_W] = mem_rdata_i;
  end

  mem_load_ext u_load_ext (
    .aluop   (op_q),
    .word    (word_asm),
    .value_c (load_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      k_q        <= '0;
      last_q     <= '0;
      word_q     <= '0;
      wb_q       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      op_q       <= op_n;
      addr_q     <= addr_n;
      sdata_q    <= sdata_n;
      wd_q       <= wd_n;
      wreg_q     <= wreg_n;
      k_q        <= k_n;
      last_q     <= last_n;
      word_q     <= word_n;
      wb_q       <= wb_n;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_n;
`endif
    end
  end

  always_comb begin
    state_n     = state_q;
    op_n        = op_q;
    addr_n      = addr_q;
    sdata_n     = sdata_q;
    wd_n        = wd_q;
    wreg_n      = wreg_q;
    k_n         = k_q;
    last_n      = last_q;
    word_n      = word_q;
    wb_n        = '0;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_n  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (valid_i && is_mem_op(aluop_i)) begin
          stall_req_o = 1'b1;
          op_n        = aluop_i;
          addr_n      = mem_addr_i;
          sdata_n     = data_i;
          wd_n        = wd_i;
          wreg_n      = wreg_i;
          k_n         = 2'd0;
          last_n      = last_byte(aluop_i);
          word_n      = '0;
          state_n     = ACCESS;
`ifdef MEM_MISALIGN_TRAP_EN
          // Trapped ops skip the bus and report straight from DONE.
          if (is_misaligned(aluop_i, mem_addr_i)) begin
            state_n    = DONE;
            wb_n.valid = 1'b1;
            wb_n.wd    = wd_i;
            misalign_n = 1'b1;
          end
`endif
        end else if (valid_i) begin
          wb_n.valid = 1'b1;
          wb_n.wd    = wd_i;
          wb_n.wreg  = wreg_i;
          wb_n.data  = data_i;
        end
      end

      ACCESS: begin
        stall_req_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = is_store(op_q);
        mem_addr_o  = addr_q + REG_W'(k_q);
        mem_wdata_o = sdata_q[{k_q, 3'b000} +: BYTE_W];
        if (mem_ready_i) begin
          word_n = word_asm;
          if (k_q == last_q) begin
            state_n    = DONE;
            wb_n.valid = 1'b1;
            wb_n.wd    = wd_q;
            wb_n.wreg  = wreg_q;
            wb_n.data  = is_store(op_q) ? '0 : load_val;
          end else begin
            k_n = k_q + 2'd1;
          end
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

  assign valid_o = wb_q.valid;
  assign wd_o    = wb_q.wd;
  assign wreg_o  = wb_q.wreg;
  assign data_o  = wb_q.data;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a wait-state byte memory.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 valid_i;
  logic [ALUOP_W-1:0]   aluop_i;
  logic [REGADDR_W-1:0] wd_i;
  logic                 wreg_i;
  logic [REG_W-1:0]     data_i;
  logic [REG_W-1:0]     mem_addr_i;
  logic                 stall_req_o;
  logic                 valid_o;
  logic [REGADDR_W-1:0] wd_o;
  logic                 wreg_o;
  logic [REG_W-1:0]     data_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [REG_W-1:0]     mem_addr_o;
  logic [BYTE_W-1:0]    mem_wdata_o;
  logic [BYTE_W-1:0]    mem_rdata_i;
  logic                 mem_ready_i;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                 misalign_o;
`endif

  mem_stage dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .aluop_i     (aluop_i),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .data_i      (data_i),
    .mem_addr_i  (mem_addr_i),
    .stall_req_o (stall_req_o),
    .valid_o     (valid_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .data_o      (data_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_o  (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  // Read-only byte image (low 10 address bits) plus a log of accepted beats.
  logic [7:0]  rom [0:1023];
  int          waits;
  int          wcnt;
  int          log_n;
  logic [31:0] log_addr [0:63];
  logic [7:0]  log_data [0:63];
  logic        log_we   [0:63];

  assign mem_rdata_i = rom[mem_addr_o[9:0]];
  assign mem_ready_i = mem_req_o && (wcnt == waits);

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0;
    end else if (mem_req_o) begin
      if (mem_ready_i) begin
        wcnt                 <= 0;
        log_addr[log_n[5:0]] <= mem_addr_o;
        log_data[log_n[5:0]] <= mem_we_o ? mem_wdata_o : mem_rdata_i;
        log_we[log_n[5:0]]   <= mem_we_o;
        log_n                <= log_n + 1;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one instruction from EX/MEM; it advances once stall_req_o is low.
  task automatic run_op(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                        input logic [31:0] data, input logic [31:0] addr,
                        output int lat, output int stalls);
    logic st;
    bit   done;
    lat = 0; stalls = 0; done = 0;
    @(negedge clk);
    valid_i = 1'b1; aluop_i = op; wd_i = wd; wreg_i = wreg;
    data_i = data; mem_addr_i = addr;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      st = stall_req_o;
      if (st) stalls++;
      @(negedge clk);
      lat++;
      if (!st) valid_i = 1'b0;
      if (valid_o) begin
        done    = 1;
        valid_i = 1'b0;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
  endtask

  int lat, stalls, base;

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    rom[10'h100] = 8'h80;
    rom[10'h3ff] = 8'h34;
    rom[10'h000] = 8'h82;
    rom[10'h300] = 8'h11; rom[10'h301] = 8'h22;
    rom[10'h302] = 8'h33; rom[10'h303] = 8'h44;
    waits = 0; log_n = 0;
    rst = 1'b1; valid_i = 1'b0; aluop_i = OP_NOP; wd_i = '0; wreg_i = 1'b0;
    data_i = '0; mem_addr_i = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_stall", 32'(stall_req_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(valid_o), 32'd0);

    // ALU pass-through
    run_op(OP_ADD, 5'd5, 1'b1, 32'h0000_1234, 32'h0, lat, stalls);
    check("add_lat", 32'(lat), 32'd1);
    check("add_stall", 32'(stalls), 32'd0);
    check("add_data", data_o, 32'h0000_1234);
    check("add_wd", 32'(wd_o), 32'd5);
    check("add_wreg", 32'(wreg_o), 32'd1);
    @(negedge clk);
    check("add_valid_drop", 32'(valid_o), 32'd0);

    // Lb / Lbu from 0x100 holding 0x80
    base = log_n;
    run_op(OP_LB, 5'd6, 1'b1, 32'h0, 32'h0000_0100, lat, stalls);
    check("lb_data", data_o, 32'hFFFF_FF80);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_beats", 32'(log_n - base), 32'd1);
    check("lb_addr", log_addr[base[5:0]], 32'h0000_0100);
    check("lb_done_stall", 32'(stall_req_o), 32'd0);
    run_op(OP_LBU, 5'd7, 1'b1, 32'h0, 32'h0000_0100, lat, stalls);
    check("lbu_data", data_o, 32'h0000_0080);
    check("lbu_wd", 32'(wd_o), 32'd7);

    // Sw with two wait states per byte
    waits = 2;
    base = log_n;
    run_op(OP_SW, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0200, lat, stalls);
    check("sw_lat", 32'(lat), 32'd13);
    check("sw_stall_cycles", 32'(stalls), 32'd13);
    check("sw_data", data_o, 32'd0);
    check("sw_wreg", 32'(wreg_o), 32'd0);
    check("sw_beats", 32'(log_n - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_word;
      logic [5:0]  idx;
      exp_word = 32'hDEAD_BEEF;
      idx = 6'(base + i);
      check($sformatf("sw_addr%0d", i), log_addr[idx], 32'h200 + 32'(i));
      check($sformatf("sw_byte%0d", i), 32'(log_data[idx]), 32'(exp_word[8*i +: 8]));
      check($sformatf("sw_we%0d", i), 32'(log_we[idx]), 32'd1);
    end
    @(negedge clk);
    check("sw_valid_drop", 32'(valid_o), 32'd0);
    waits = 0;

    // Lh straddling the top of the address space
    base = log_n;
    run_op(OP_LH, 5'd9, 1'b1, 32'h0, 32'hFFFF_FFFF, lat, stalls);
`ifdef MEM_MISALIGN_TRAP_EN
    check("lh_trap_lat", 32'(lat), 32'd1);
    check("lh_trap_flag", 32'(misalign_o), 32'd1);
    check("lh_trap_data", data_o, 32'd0);
    check("lh_trap_wreg", 32'(wreg_o), 32'd0);
    check("lh_trap_beats", 32'(log_n - base), 32'd0);
    @(negedge clk);
    check("lh_trap_clear", 32'(misalign_o), 32'd0);
`else
    check("lh_data", data_o, 32'hFFFF_8234);
    check("lh_lat", 32'(lat), 32'd3);
    check("lh_beats", 32'(log_n - base), 32'd2);
    check("lh_addr0", log_addr[base[5:0]], 32'hFFFF_FFFF);
    check("lh_addr1", log_addr[6'(base + 1)], 32'h0000_0000);
`endif

    // Reset in the middle of an Lw, then a clean Lw
    @(negedge clk);
    valid_i = 1'b1; aluop_i = OP_LW; wd_i = 5'd3; wreg_i = 1'b1; mem_addr_i = 32'h300;
    repeat (3) @(negedge clk);
    check("lw_pre_rst_req", 32'(mem_req_o), 32'd1);
    check("lw_pre_rst_addr", mem_addr_o, 32'h0000_0302);
    rst = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    check("mid_rst_req", 32'(mem_req_o), 32'd0);
    check("mid_rst_stall", 32'(stall_req_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_wd", 32'(wd_o), 32'd0);
    check("mid_rst_addr", mem_addr_o, 32'd0);
    rst = 1'b0;
    run_op(OP_LW, 5'd3, 1'b1, 32'h0, 32'h0000_0300, lat, stalls);
    check("lw_data", data_o, 32'h4433_2211);
    check("lw_lat", 32'(lat), 32'd5);
    check("lw_wd", 32'(wd_o), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
